// File: rtl/ir_nec_rx.sv
// NEC infrared frame decoder. Samples the receiver pin on a 1 us tick, classifies each
// mark/space against timing windows and reports frames, repeat codes and errors.
module ir_nec_rx #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter bit          RX_INVERT  = 1'b1,
   parameter bit          CHECK_ADDR = 1'b0,
   parameter bit          CHECK_CMD  = 1'b1,
   parameter int unsigned TIMEOUT_US = 12000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_ir_rx,
   output logic [31:0] o_data,
   output logic        o_valid,
   output logic        o_repeat,
   output logic        o_err,
   output logic [1:0]  o_err_code,
   output logic        o_busy
);

   localparam int unsigned TickDiv  = CLK_HZ / 1_000_000;
   localparam int unsigned TickW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
   localparam logic [TickW-1:0] TickLast = TickW'(TickDiv - 1);
   localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_US);

   localparam logic [1:0] ErrNone    = 2'b00;
   localparam logic [1:0] ErrTiming  = 2'b01;
   localparam logic [1:0] ErrCheck   = 2'b10;
   localparam logic [1:0] ErrTimeout = 2'b11;

   typedef enum logic [2:0] {
      StIdle, StLeadMark, StLeadSpace, StBitMark, StBitSpace, StStopMark
   } state_e;

   state_e state_q, state_d;

   logic [1:0]       sync_q;
   logic             ir, ir_q, tick, rise, fall;
   logic [TickW-1:0] tick_cnt_q;
   logic [15:0]      dur_q;

   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [31:0] sr_q, sr_d, data_q, data_d;
   logic        rep_q, rep_d, seen_q, seen_d;
   logic        valid_q, valid_d, repeat_q, repeat_d, err_q, err_d;
   logic [1:0]  err_code_q, err_code_d, err_set;
   logic        win_lead, win_data_sp, win_rep_sp, win_mark, win_zero, win_one, chk_ok;

   function automatic logic in_win(input logic [15:0] d, input logic [15:0] lo,
                                   input logic [15:0] hi);
      return (d >= lo) && (d <= hi);
   endfunction

   assign ir   = sync_q[1] ^ RX_INVERT;
   assign tick = (tick_cnt_q == TickLast);
   assign rise = tick & ir & ~ir_q;
   assign fall = tick & ~ir & ir_q;

   // Synchroniser resets to the idle pin level so reset release never looks like a mark.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= {2{RX_INVERT}};
         tick_cnt_q <= '0;
         ir_q       <= 1'b0;
         dur_q      <= '0;
      end else begin
         sync_q     <= {sync_q[0], i_ir_rx};
         tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
         if (tick) begin
            ir_q <= ir;
            if (rise || fall) begin
               dur_q <= '0;
            end else if (dur_q != 16'hFFFF) begin
               dur_q <= dur_q + 16'd1;
            end
         end
      end
   end

   assign win_lead    = in_win(dur_q, 16'd8000, 16'd10000);
   assign win_data_sp = in_win(dur_q, 16'd4000, 16'd5000);
   assign win_rep_sp  = in_win(dur_q, 16'd2000, 16'd2500);
   assign win_mark    = in_win(dur_q, 16'd400, 16'd700);
   assign win_zero    = in_win(dur_q, 16'd400, 16'd700);
   assign win_one     = in_win(dur_q, 16'd1400, 16'd1900);

   assign chk_ok = (!CHECK_ADDR || (sr_q[31:24] == ~sr_q[23:16])) &&
                   (!CHECK_CMD  || (sr_q[15:8]  == ~sr_q[7:0]));

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      sr_d       = sr_q;
      rep_d      = rep_q;
      data_d     = data_q;
      seen_d     = seen_q;
      valid_d    = 1'b0;
      repeat_d   = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      err_set    = ErrNone;

      unique case (state_q)
         StIdle: begin
            if (rise) state_d = StLeadMark;
         end
         StLeadMark: begin
            // Out-of-window lead marks are treated as noise, not errors.
            if (fall) state_d = win_lead ? StLeadSpace : StIdle;
         end
         StLeadSpace: begin
            if (rise) begin
               if (win_data_sp) begin
                  state_d   = StBitMark;
                  bit_cnt_d = '0;
                  rep_d     = 1'b0;
               end else if (win_rep_sp) begin
                  state_d = StStopMark;
                  rep_d   = 1'b1;
               end else begin
                  err_set = ErrTiming;
               end
            end
         end
         StBitMark: begin
            if (fall) begin
               if (win_mark) state_d = StBitSpace;
               else          err_set = ErrTiming;
            end
         end
         StBitSpace: begin
            if (rise) begin
               if (win_zero || win_one) begin
                  sr_d      = {sr_q[30:0], win_one};
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  state_d   = (bit_cnt_d == 6'd32) ? StStopMark : StBitMark;
               end else begin
                  err_set = ErrTiming;
               end
            end
         end
         StStopMark: begin
            if (fall) begin
               if (!win_mark) begin
                  err_set = ErrTiming;
               end else if (rep_q) begin
                  repeat_d = seen_q;
                  state_d  = StIdle;
               end else if (chk_ok) begin
                  data_d  = sr_q;
                  valid_d = 1'b1;
                  seen_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  err_set = ErrCheck;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if ((state_q != StIdle) && !rise && !fall && (dur_q == TimeoutCnt)) begin
         err_set = ErrTimeout;
      end

      if (err_set != ErrNone) begin
         err_d      = 1'b1;
         err_code_d = err_set;
         state_d    = StIdle;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         sr_q       <= '0;
         rep_q      <= 1'b0;
         data_q     <= '0;
         seen_q     <= 1'b0;
         valid_q    <= 1'b0;
         repeat_q   <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ErrNone;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         sr_q       <= sr_d;
         rep_q      <= rep_d;
         data_q     <= data_d;
         seen_q     <= seen_d;
         valid_q    <= valid_d;
         repeat_q   <= repeat_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign o_data     = data_q;
   assign o_valid    = valid_q;
   assign o_repeat   = repeat_q;
   assign o_err      = err_q;
   assign o_err_code = err_code_q;
   assign o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ir_nec_rx.sv
// Self-checking bench for ir_nec_rx: randomised NEC pulse trains against a frame-level
// reference model (accept/reject rules, frame-seen flag, expected error codes).
`timescale 1ns/1ps
module tb_ir_nec_rx;

   localparam int unsigned CLK_HZ   = 2_000_000;
   localparam int          TPU      = 2;      // clk cycles per microsecond
   localparam bit          CHK_ADDR = 1'b0;
   localparam bit          CHK_CMD  = 1'b1;
   localparam logic        MARK     = 1'b0;   // active-low receiver
   localparam logic        SPACE    = 1'b1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ir_pin = 1'b1;
   logic [31:0] o_data;
   logic        o_valid, o_repeat, o_err, o_busy;
   logic [1:0]  o_err_code;

   always #5 clk = ~clk;

   ir_nec_rx #(
      .CLK_HZ     (CLK_HZ),
      .RX_INVERT  (1'b1),
      .CHECK_ADDR (CHK_ADDR),
      .CHECK_CMD  (CHK_CMD),
      .TIMEOUT_US (12000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_ir_rx    (ir_pin),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_repeat   (o_repeat),
      .o_err      (o_err),
      .o_err_code (o_err_code),
      .o_busy     (o_busy)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_edge_cyc = 0;
   int n_valid = 0, n_repeat = 0, n_err = 0, excl_viol = 0, width_viol = 0, err_cyc = 0;
   logic pv = 1'b0, pr = 1'b0, pe = 1'b0;

   logic [31:0] exp_data = '0;
   bit          seen = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_valid)  n_valid  <= n_valid + 1;
      if (o_repeat) n_repeat <= n_repeat + 1;
      if (o_err) begin
         n_err   <= n_err + 1;
         err_cyc <= cyc;
      end
      if (int'(o_valid) + int'(o_repeat) + int'(o_err) > 1) excl_viol <= excl_viol + 1;
      if ((o_valid && pv) || (o_repeat && pr) || (o_err && pe)) width_viol <= width_viol + 1;
      pv <= o_valid;
      pr <= o_repeat;
      pe <= o_err;
   end

   function automatic int rnd(input int lo, input int hi);
      return int'($urandom_range(32'(hi), 32'(lo)));
   endfunction

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   // Frame acceptance rule, applied to bytes in on-air order.
   function automatic bit model_accept(input logic [31:0] w);
      return (!CHK_ADDR || (w[31:24] == ~w[23:16])) && (!CHK_CMD || (w[15:8] == ~w[7:0]));
   endfunction

   function automatic logic [31:0] good_word();
      logic [7:0] c;
      c = 8'($urandom);
      return {8'($urandom), 8'($urandom), c, ~c};
   endfunction

   task automatic drive(input logic lvl, input int us);
      if (ir_pin !== lvl) begin
         ir_pin = lvl;
         last_edge_cyc = cyc;
      end
      repeat (us * TPU) @(negedge clk);
   endtask

   task automatic send_frame(input logic [31:0] word, input int nbits, input bit stop,
                             input int bad_idx);
      drive(MARK, rnd(8005, 9995));
      drive(SPACE, rnd(4005, 4995));
      for (int i = 0; i < nbits; i++) begin
         drive(MARK, rnd(405, 695));
         if (i == bad_idx) begin
            drive(SPACE, 1000);
            drive(MARK, rnd(405, 695));
            drive(SPACE, 500);
            return;
         end
         drive(SPACE, word[31-i] ? rnd(1405, 1895) : rnd(405, 695));
      end
      if (stop) begin
         drive(MARK, rnd(405, 695));
         drive(SPACE, 500);
      end
   endtask

   task automatic send_repeat();
      drive(MARK, rnd(8005, 9995));
      drive(SPACE, rnd(2005, 2495));
      drive(MARK, rnd(405, 695));
      drive(SPACE, 500);
   endtask

   task automatic model_frame(input logic [31:0] w);
      if (model_accept(w)) begin
         exp_data = w;
         seen = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      exp_data = '0;
      seen = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      int busy_seen = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 200; i++) begin
         ir_pin = 1'($urandom_range(1, 0));
         @(negedge clk);
      end
      checks++;
      if ({o_data, o_valid, o_repeat, o_err, o_err_code, o_busy} !== 38'd0) begin
         failures++;
         $display("FAIL reset_outputs: got data=%h v=%b r=%b e=%b code=%b busy=%b required all 0",
                  o_data, o_valid, o_repeat, o_err, o_err_code, o_busy);
      end
      ir_pin = SPACE;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (200 * TPU) begin
         @(negedge clk);
         if (o_busy) busy_seen++;
      end
      checks++;
      if (busy_seen != 0) begin
         failures++;
         $display("FAIL reset_idle_busy: busy high for %0d cycles, required 0", busy_seen);
      end
      checks++;
      if (n_valid + n_repeat + n_err != 0) begin
         failures++;
         $display("FAIL reset_no_pulses: got %0d pulses, required 0", n_valid + n_repeat + n_err);
      end
   endtask

   task automatic test_frame();
      logic [31:0] w;
      int v0 = n_valid, e0 = n_err;
      w = {rev8(8'h00), rev8(8'hFF), rev8(8'h45), rev8(8'hBA)};
      send_frame(w, 32, 1'b1, -1);
      model_frame(w);
      checks++;
      if (n_valid - v0 != 1) begin
         failures++;
         $display("FAIL frame_valid_count: got %0d required 1", n_valid - v0);
      end
      checks++;
      if (n_err != e0) begin
         failures++;
         $display("FAIL frame_no_err: got %0d errors required 0", n_err - e0);
      end
      checks++;
      if (o_data !== exp_data) begin
         failures++;
         $display("FAIL frame_data_model: got %h required %h", o_data, exp_data);
      end
      checks++;
      if (o_data !== 32'h00FFA25D) begin
         failures++;
         $display("FAIL frame_data_literal: got %h required 00ffa25d", o_data);
      end
   endtask

   task automatic test_repeat();
      int v0, r0;
      drive(SPACE, 2000);
      v0 = n_valid;
      r0 = n_repeat;
      send_repeat();
      checks++;
      if (n_repeat - r0 != 1) begin
         failures++;
         $display("FAIL repeat_count: got %0d required 1", n_repeat - r0);
      end
      checks++;
      if ((n_valid != v0) || (o_data !== exp_data)) begin
         failures++;
         $display("FAIL repeat_data_hold: got %h (+%0d valid) required %h", o_data,
                  n_valid - v0, exp_data);
      end
   endtask

   task automatic test_check_err();
      logic [31:0] w;
      int v0 = n_valid, e0 = n_err;
      bit ok;
      w = {rev8(8'h00), rev8(8'hFF), rev8(8'h45), rev8(8'hBB)};
      ok = model_accept(w);
      send_frame(w, 32, 1'b1, -1);
      model_frame(w);
      checks++;
      if ((n_err - e0 != int'(!ok)) || (n_valid - v0 != int'(ok))) begin
         failures++;
         $display("FAIL check_err_pulses: got err=%0d valid=%0d required err=%0d valid=%0d",
                  n_err - e0, n_valid - v0, int'(!ok), int'(ok));
      end
      checks++;
      if (o_err_code !== 2'b10) begin
         failures++;
         $display("FAIL check_err_code: got %b required 10", o_err_code);
      end
      checks++;
      if (o_data !== exp_data) begin
         failures++;
         $display("FAIL check_err_data_hold: got %h required %h", o_data, exp_data);
      end
   endtask

   task automatic test_repeat_after_reset();
      int v0, r0, e0;
      do_reset();
      v0 = n_valid;
      r0 = n_repeat;
      e0 = n_err;
      send_repeat();
      checks++;
      if ((n_valid != v0) || (n_repeat != r0) || (n_err != e0)) begin
         failures++;
         $display("FAIL repeat_after_reset: got v=%0d r=%0d e=%0d pulses required none",
                  n_valid - v0, n_repeat - r0, n_err - e0);
      end
      checks++;
      if (o_data !== exp_data) begin
         failures++;
         $display("FAIL repeat_after_reset_data: got %h required %h", o_data, exp_data);
      end
   endtask

   task automatic test_timeout();
      logic [31:0] w;
      int e0 = n_err, v0, guard = 0, lat;
      send_frame(good_word(), 20, 1'b0, -1);
      while ((n_err == e0) && (guard < 13000 * TPU)) begin
         @(negedge clk);
         guard++;
      end
      repeat (4) @(negedge clk);
      checks++;
      if (n_err - e0 != 1) begin
         failures++;
         $display("FAIL timeout_err_count: got %0d required 1", n_err - e0);
      end
      checks++;
      if (o_err_code !== 2'b11) begin
         failures++;
         $display("FAIL timeout_code: got %b required 11", o_err_code);
      end
      // Allowance: +/-2 us of tick resolution plus synchroniser/tick/output-register delay.
      lat = err_cyc - last_edge_cyc;
      checks++;
      if ((lat < 11998 * TPU) || (lat > 12002 * TPU + 6)) begin
         failures++;
         $display("FAIL timeout_latency: got %0d cycles required %0d..%0d", lat,
                  11998 * TPU, 12002 * TPU + 6);
      end
      checks++;
      if (o_busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_busy: got %b required 0", o_busy);
      end
      w = good_word();
      v0 = n_valid;
      send_frame(w, 32, 1'b1, -1);
      model_frame(w);
      checks++;
      if ((n_valid - v0 != 1) || (o_data !== exp_data)) begin
         failures++;
         $display("FAIL timeout_recover: got %0d valid data %h required 1 valid data %h",
                  n_valid - v0, o_data, exp_data);
      end
   endtask

   task automatic test_timing_err();
      int e0 = n_err, v0 = n_valid;
      send_frame(good_word(), 32, 1'b1, 5);
      checks++;
      if ((n_err - e0 != 1) || (n_valid != v0)) begin
         failures++;
         $display("FAIL timing_err_count: got err=%0d valid=%0d required err=1 valid=0",
                  n_err - e0, n_valid - v0);
      end
      checks++;
      if (o_err_code !== 2'b01) begin
         failures++;
         $display("FAIL timing_err_code: got %b required 01", o_err_code);
      end
      checks++;
      if (o_data !== exp_data) begin
         failures++;
         $display("FAIL timing_err_data_hold: got %h required %h", o_data, exp_data);
      end
      e0 = n_err;
      drive(MARK, 3000);
      drive(SPACE, 500);
      checks++;
      if ((n_err != e0) || (o_busy !== 1'b0)) begin
         failures++;
         $display("FAIL short_lead_noise: got err=%0d busy=%b required err=0 busy=0",
                  n_err - e0, o_busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] w;
      int v0;
      send_frame(good_word(), 12, 1'b0, -1);
      do_reset();
      checks++;
      if ((o_data !== exp_data) || (o_busy !== 1'b0)) begin
         failures++;
         $display("FAIL mid_reset_state: got data=%h busy=%b required data=%h busy=0",
                  o_data, o_busy, exp_data);
      end
      w = good_word();
      v0 = n_valid;
      send_frame(w, 32, 1'b1, -1);
      model_frame(w);
      checks++;
      if ((n_valid - v0 != 1) || (o_data !== exp_data)) begin
         failures++;
         $display("FAIL mid_reset_recover: got %0d valid data %h required 1 valid data %h",
                  n_valid - v0, o_data, exp_data);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 2; k++) begin
         logic [31:0] w;
         bit ok;
         int v0 = n_valid, e0 = n_err, r0;
         w = $urandom;
         if ($urandom_range(1, 0) == 1) w[7:0] = ~w[15:8];
         ok = model_accept(w);
         send_frame(w, 32, 1'b1, -1);
         model_frame(w);
         checks++;
         if ((n_valid - v0 != int'(ok)) || (n_err - e0 != int'(!ok))) begin
            failures++;
            $display("FAIL random_pulses[%0d]: w=%h got valid=%0d err=%0d required %0d/%0d",
                     k, w, n_valid - v0, n_err - e0, int'(ok), int'(!ok));
         end
         checks++;
         if (o_data !== exp_data) begin
            failures++;
            $display("FAIL random_data[%0d]: got %h required %h", k, o_data, exp_data);
         end
         if (!ok) begin
            checks++;
            if (o_err_code !== 2'b10) begin
               failures++;
               $display("FAIL random_err_code[%0d]: got %b required 10", k, o_err_code);
            end
         end
         r0 = n_repeat;
         drive(SPACE, 1000);
         send_repeat();
         checks++;
         if (n_repeat - r0 != int'(seen)) begin
            failures++;
            $display("FAIL random_repeat[%0d]: got %0d required %0d", k, n_repeat - r0,
                     int'(seen));
         end
      end
   endtask

   task automatic test_pulse_props();
      checks++;
      if (excl_viol != 0) begin
         failures++;
         $display("FAIL pulse_exclusive: got %0d overlapping cycles required 0", excl_viol);
      end
      checks++;
      if (width_viol != 0) begin
         failures++;
         $display("FAIL pulse_width: got %0d multi-cycle pulses required 0", width_viol);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_frame();
      test_repeat();
      test_check_err();
      test_repeat_after_reset();
      test_timeout();
      test_timing_err();
      test_reset_mid_frame();
      test_random();
      test_pulse_props();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
